// File: rtl/viterbi_chan_inj.sv
// viterbi_chan_inj
// Channel error injector placed between a convolutional encoder and a Viterbi
// decoder. Each valid symbol passes through with a fixed 1-cycle latency. It
// can be corrupted by XOR with err_mask_i in three ways: a periodic burst,
// an LFSR-driven random hit, or both. Injection is confined to a window of
// WORD_LIMIT words after reset.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   mode_i           00 bypass, 01 periodic burst, 10 random, 11 burst|random
//   burst_off_i      burst start position within the 2**PER_LOG2 word period
//   burst_len_i      burst length in words (clamped to MAX_BURST)
//   err_mask_i       bits flipped in an injected symbol
//   ber_thr_i        random hit when lfsr[7:0] < ber_thr_i
//   valid_i, sym_i   input symbol stream
//   valid_o, sym_o   output symbol stream (1-cycle latency)
//   err_o            sym_o carries at least one flipped bit
//   word_ct_o        valid words accepted (saturating)
//   inj_sym_ct_o     corrupted symbols (saturating)
//   inj_bit_ct_o     flipped bits (saturating)
//   busy_o           burst FSM in BURST
module viterbi_chan_inj #(
    parameter int          SYM_W      = 2,
    parameter int          PER_LOG2   = 4,
    parameter int          MAX_BURST  = 4,
    parameter int          WORD_LIMIT = 256,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       mode_i,
    input  logic [PER_LOG2-1:0]              burst_off_i,
    input  logic [$clog2(MAX_BURST+1)-1:0]   burst_len_i,
    input  logic [SYM_W-1:0]                 err_mask_i,
    input  logic [7:0]                       ber_thr_i,
    input  logic                             valid_i,
    input  logic [SYM_W-1:0]                 sym_i,
    output logic                             valid_o,
    output logic [SYM_W-1:0]                 sym_o,
    output logic                             err_o,
    output logic [31:0]                      word_ct_o,
    output logic [31:0]                      inj_sym_ct_o,
    output logic [31:0]                      inj_bit_ct_o,
    output logic                             busy_o
);

    localparam int LW = $clog2(MAX_BURST+1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     rem_q, rem_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [31:0]       word_ct_q, word_ct_d;
    logic [31:0]       inj_sym_q, inj_sym_d;
    logic [31:0]       inj_bit_q, inj_bit_d;
    logic              valid_q;
    logic [SYM_W-1:0]  sym_q;
    logic              err_q;

    logic              win_open;
    logic [LW-1:0]     len_eff;
    logic              pos_hit;
    logic              burst_hit;
    logic              rand_hit;
    logic              inject;
    logic              err_d;
    logic [31:0]       pop;
    logic [32:0]       bit_sum;

    // Window is judged on the count before this word is added.
    assign win_open = (WORD_LIMIT == 0) || (word_ct_q < 32'(WORD_LIMIT));
    assign len_eff  = (burst_len_i > LW'(MAX_BURST)) ? LW'(MAX_BURST) : burst_len_i;
    assign pos_hit  = (word_ct_q[PER_LOG2-1:0] == burst_off_i);

    // Burst FSM. Every transition is qualified by valid_i, so idle cycles
    // never move the burst along; a closed window parks the FSM in DONE.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        burst_hit = 1'b0;
        if (valid_i) begin
            if (!win_open) begin
                state_d = DONE;
                rem_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (mode_i[0] && (len_eff != '0) && pos_hit) begin
                            burst_hit = 1'b1;
                            rem_d     = len_eff - LW'(1);
                            state_d   = (len_eff == LW'(1)) ? IDLE : BURST;
                        end
                    end
                    BURST: begin
                        // Position match is ignored here: no retrigger or extension.
                        if (!mode_i[0]) begin
                            state_d = IDLE;
                            rem_d   = '0;
                        end else begin
                            burst_hit = 1'b1;
                            rem_d     = rem_q - LW'(1);
                            if (rem_q == LW'(1)) state_d = IDLE;
                        end
                    end
                    DONE:    state_d = DONE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Random path uses the pre-advance LFSR value.
    assign rand_hit = valid_i && mode_i[1] && win_open && (lfsr_q[7:0] < ber_thr_i);
    assign inject   = burst_hit || rand_hit;
    assign err_d    = inject && (|err_mask_i);

    always_comb begin
        pop = '0;
        for (int i = 0; i < SYM_W; i++) pop = pop + 32'(err_mask_i[i]);
    end

    assign bit_sum = {1'b0, inj_bit_q} + {1'b0, pop};

    always_comb begin
        lfsr_d    = lfsr_q;
        word_ct_d = word_ct_q;
        inj_sym_d = inj_sym_q;
        inj_bit_d = inj_bit_q;
        if (valid_i) begin
            // Fibonacci taps 16,14,13,11.
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            if (word_ct_q != 32'hFFFF_FFFF) word_ct_d = word_ct_q + 32'd1;
            if (err_d) begin
                if (inj_sym_q != 32'hFFFF_FFFF) inj_sym_d = inj_sym_q + 32'd1;
                inj_bit_d = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            word_ct_q <= '0;
            inj_sym_q <= '0;
            inj_bit_q <= '0;
            valid_q   <= 1'b0;
            sym_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            lfsr_q    <= lfsr_d;
            word_ct_q <= word_ct_d;
            inj_sym_q <= inj_sym_d;
            inj_bit_q <= inj_bit_d;
            valid_q   <= valid_i;
            if (valid_i) begin
                sym_q <= inject ? (sym_i ^ err_mask_i) : sym_i;
                err_q <= err_d;
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    assign valid_o      = valid_q;
    assign sym_o        = sym_q;
    assign err_o        = err_q;
    assign word_ct_o    = word_ct_q;
    assign inj_sym_ct_o = inj_sym_q;
    assign inj_bit_ct_o = inj_bit_q;
    assign busy_o       = (state_q == BURST);

endmodule
